// File: rtl/mem_if.sv
// Request/response bus between a memory client (master) and mem_responder (slave).
// Requests are sampled only when the responder is idle; completion is a one-cycle MemReady pulse.
interface mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  StoreX;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        MemReady;
  logic        MemBusy;
  logic        AddrErr;

  modport master (
    output MemRead, MemWrite, StoreX, address, writedata,
    input  readdata, MemReady, MemBusy, AddrErr
  );

  modport slave (
    input  MemRead, MemWrite, StoreX, address, writedata,
    output readdata, MemReady, MemBusy, AddrErr
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory model with fixed access latency, sub-word stores and range checking.
// One request in flight at a time: IDLE accepts, BUSY counts down, DONE pulses MemReady.
module mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 16384
) (
  input logic  clk,
  input logic  rst_n,
  mem_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          is_write_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          finish;
  logic          in_range;
  logic          size_bad;
  logic [AW-1:0] idx;

  assign accept   = (state_q == IDLE) && (bus.MemRead || bus.MemWrite);
  assign finish   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign in_range = addr_q < 32'(DEPTH);
  assign size_bad = is_write_q && (size_q == 2'b11);
  assign idx      = addr_q[AW-1:0];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.MemReady = (state_q == DONE);
    bus.MemBusy  = (state_q != IDLE);
    bus.AddrErr  = (state_q == DONE) && err_q;
    bus.readdata = rdata_q;
  end

  // Request latch, latency counter and read result; inputs are ignored outside acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= 4'(LATENCY - 1);
        is_write_q <= bus.MemWrite;
        size_q     <= bus.StoreX;
        addr_q     <= bus.address;
        wdata_q    <= bus.writedata;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (finish) begin
        err_q <= !in_range || size_bad;
        if (!is_write_q) rdata_q <= in_range ? mem[idx] : 32'h0;
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (finish && is_write_q && in_range) begin
      unique case (size_q)
        2'b00:   mem[idx]       <= wdata_q;
        2'b01:   mem[idx][15:0] <= wdata_q[15:0];
        2'b10:   mem[idx][7:0]  <= wdata_q[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to MemReady (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 16384, meaning number of 32-bit words stored.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port MemRead  input  1  read request.
REQ-006 SHALL have port MemWrite  input  1  write request.
REQ-007 SHALL have port StoreX  input  2  write size: 00 word, 01 half (bits 15:0), 10 byte (bits 7:0), 11 reserved.
REQ-008 SHALL have port address  input  32  word index (not byte address).
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  read data.
REQ-011 SHALL have port MemReady  output  1  one-cycle completion pulse.
REQ-012 SHALL have port MemBusy  output  1  high while a request is in flight.
REQ-013 SHALL have port AddrErr  output  1  one-cycle pulse, coincident with MemReady, for an out-of-range request.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 IDLE: SHALL accept a request on a rising edge where MemRead or MemWrite is high; SHALL latch address, writedata, StoreX, and op; SHALL load the latency counter with LATENCY-1; next state BUSY.
REQ-016 SHALL treat MemRead and MemWrite both high as a write; the read is dropped.
REQ-017 BUSY: SHALL decrement the counter each cycle; on count 0 SHALL perform the latched op and enter DONE.
REQ-018 SHALL make MemReady rise exactly LATENCY cycles after the accepting edge; with LATENCY=1 BUSY lasts one cycle.
REQ-019 DONE: SHALL assert MemReady for exactly one cycle; next state IDLE.
REQ-020 SHALL accept no new request in DONE; a request held high is accepted on the first IDLE edge, giving a throughput of LATENCY+2 cycles per request.
REQ-021 SHALL assert MemBusy in BUSY and DONE, deasserted in IDLE.
REQ-022 SHALL sample input changes only at acceptance; changes during BUSY/DONE SHALL be ignored.
REQ-023 Word write SHALL replace all 32 bits.
REQ-024 Half write SHALL replace bits 15:0 and preserve bits 31:16.
REQ-025 Byte write SHALL replace bits 7:0 and preserve bits 31:8.
REQ-026 StoreX=11 SHALL leave memory unchanged and pulse AddrErr.
REQ-027 Read SHALL update readdata with the full word in the DONE cycle; readdata SHALL hold until the next read completes; writes SHALL not alter readdata.
REQ-028 An address at or above DEPTH SHALL perform no memory access and pulse AddrErr with MemReady; for reads, readdata SHALL become 0.
REQ-029 An address of DEPTH-1 SHALL be in range; indexing SHALL NOT wrap modulo DEPTH.

Reset
REQ-030 While rst_n=0, SHALL force state IDLE, counter 0, MemReady 0, MemBusy 0, AddrErr 0, readdata 0, immediately and without clk.
REQ-031 Reset mid-BUSY SHALL abort the request with no memory update and no MemReady pulse.
REQ-032 Storage array SHALL NOT be cleared by reset; contents persist across reset and are undefined after power-up.
REQ-033 After rst_n rises, SHALL accept requests from the first rising edge.

Verification
REQ-034 LATENCY=2: write addr 5 data 0x12345678 StoreX=00, then read addr 5 -> MemReady 2 cycles after each accept; readdata=0x12345678.
REQ-035 Word 7=0xAABBCCDD; half write 0x1111EEEE; byte write 0x00000099 -> read 0xAABBEE99.
REQ-036 Read addr 16384 -> AddrErr and MemReady same cycle, readdata=0; write addr 16384 leaves word 0 unchanged.
REQ-037 Write addr 3 data 0xFFFFFFFF with rst_n pulsed low in BUSY -> no MemReady; read addr 3 returns prior value.
REQ-038 MemRead and MemWrite both high, addr 9 data 0x5 -> word 9=0x5 and readdata unchanged.
REQ-039 Fill words 0..16383 with index+1, then read all -> each readdata=index+1, one MemReady per request, LATENCY+2 cycles per request.
